// File: rtl/vj_scan_pkg.sv
// Shared types and default pyramid geometry for the Viola-Jones window scanner.
// Default level sizes are 320x240 shrunk by 1.25 per level, level 0 in the low bits.
package vj_scan_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StScan, StDone} scan_state_e;

  typedef logic [15:0] coord_t;

  localparam int unsigned DefLevels = 10;

  localparam logic [DefLevels*16-1:0] LvlWDef = {
    16'd42, 16'd53, 16'd67, 16'd83, 16'd104,
    16'd131, 16'd163, 16'd204, 16'd256, 16'd320
  };

  localparam logic [DefLevels*16-1:0] LvlHDef = {
    16'd32, 16'd40, 16'd50, 16'd62, 16'd78,
    16'd98, 16'd122, 16'd153, 16'd192, 16'd240
  };

endpackage

// File: rtl/scan_coord_gen.sv
// Level/row/col window counters with ineligible-level skipping and last-window detection.
// Limit arithmetic is 17 bits wide so coordinate + stride never wraps.
module scan_coord_gen
  import vj_scan_pkg::*;
#(
  parameter int unsigned LEVELS = 10,
  parameter int unsigned WINDOW = 24,
  parameter int unsigned STEP   = 1,
  parameter logic [LEVELS*16-1:0] LVL_W = LvlWDef,
  parameter logic [LEVELS*16-1:0] LVL_H = LvlHDef
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic       adv_i,
  output logic [3:0] level_o,
  output coord_t     row_o,
  output coord_t     col_o,
  output logic       last_o,
  output logic       any_elig_o
);

  coord_t      w_arr [16];
  coord_t      h_arr [16];
  logic [15:0] elig;

  // Pad to 16 entries so a 4-bit level index is always in range.
  for (genvar g = 0; g < 16; g++) begin : g_lvl
    if (g < LEVELS) begin : g_used
      assign w_arr[g] = LVL_W[g*16 +: 16];
      assign h_arr[g] = LVL_H[g*16 +: 16];
      assign elig[g]  = ({1'b0, w_arr[g]} >= 17'(WINDOW)) && ({1'b0, h_arr[g]} >= 17'(WINDOW));
    end else begin : g_unused
      assign w_arr[g] = '0;
      assign h_arr[g] = '0;
      assign elig[g]  = 1'b0;
    end
  end

  logic [3:0]  level_q, level_d, first_lvl, nxt_lvl;
  logic        nxt_found;
  coord_t      row_q, row_d, col_q, col_d;
  logic [16:0] col_nxt, col_lim, row_nxt, row_lim;
  logic        col_ok, row_ok;

  // Lowest eligible level overall, and lowest eligible level above the current one.
  always_comb begin
    first_lvl = '0;
    nxt_lvl   = '0;
    nxt_found = 1'b0;
    for (int l = 15; l >= 0; l--) begin
      if (elig[l]) first_lvl = 4'(l);
      if (elig[l] && (l > int'(level_q))) begin
        nxt_lvl   = 4'(l);
        nxt_found = 1'b1;
      end
    end
  end

  always_comb begin
    col_nxt = {1'b0, col_q} + 17'(STEP);
    row_nxt = {1'b0, row_q} + 17'(STEP);
    col_lim = {1'b0, w_arr[level_q]} - 17'(WINDOW);
    row_lim = {1'b0, h_arr[level_q]} - 17'(WINDOW);
    col_ok  = (col_nxt <= col_lim);
    row_ok  = (row_nxt <= row_lim);
    level_d = level_q;
    row_d   = row_q;
    col_d   = col_q;
    if (load_i) begin
      level_d = first_lvl;
      row_d   = '0;
      col_d   = '0;
    end else if (adv_i) begin
      if (col_ok) begin
        col_d = col_nxt[15:0];
      end else if (row_ok) begin
        col_d = '0;
        row_d = row_nxt[15:0];
      end else begin
        level_d = nxt_lvl;
        row_d   = '0;
        col_d   = '0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      level_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      level_q <= level_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign level_o    = level_q;
  assign row_o      = row_q;
  assign col_o      = col_q;
  assign last_o     = !col_ok && !row_ok && !nxt_found;
  assign any_elig_o = |elig;

endmodule

// File: rtl/pyramid_scan_ctrl.sv
// Frame-level scan controller: waits for the integral image to settle, then streams
// window coordinates over all eligible pyramid levels. Define SCAN_ABORT_EN for an abort input.
module pyramid_scan_ctrl
  import vj_scan_pkg::*;
#(
  parameter int unsigned LEVELS      = 10,
  parameter int unsigned WINDOW      = 24,
  parameter int unsigned STEP        = 1,
  parameter int unsigned WAIT_CYCLES = 76800,
  parameter logic [LEVELS*16-1:0] LVL_W = LvlWDef,
  parameter logic [LEVELS*16-1:0] LVL_H = LvlHDef
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        img_rdy,
  input  logic        win_ready,
`ifdef SCAN_ABORT_EN
  input  logic        abort,
`endif
  output logic        win_valid,
  output logic [3:0]  win_level,
  output logic [15:0] win_row,
  output logic [15:0] win_col,
  output logic        win_last,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  scan_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic            valid_q, busy_q, done_q, overrun_q;
  logic            abort_act, wait_end, load, adv, last_c, any_elig;

`ifdef SCAN_ABORT_EN
  assign abort_act = abort;
`else
  assign abort_act = 1'b0;
`endif

  assign wait_end = (cnt_q == CntW'(WAIT_CYCLES - 1));
  assign load     = (state_q == StWait) && wait_end && !abort_act && any_elig;
  assign adv      = (state_q == StScan) && win_ready && !abort_act && !last_c;

  scan_coord_gen #(
    .LEVELS(LEVELS),
    .WINDOW(WINDOW),
    .STEP  (STEP),
    .LVL_W (LVL_W),
    .LVL_H (LVL_H)
  ) u_coord (
    .clock_i   (clock),
    .reset_i   (reset),
    .load_i    (load),
    .adv_i     (adv),
    .level_o   (win_level),
    .row_o     (win_row),
    .col_o     (win_col),
    .last_o    (last_c),
    .any_elig_o(any_elig)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (img_rdy) begin
            state_q   <= StWait;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        StWait: begin
          if (img_rdy) overrun_q <= 1'b1;
          if (abort_act || (wait_end && !any_elig)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (wait_end) begin
            state_q <= StScan;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StScan: begin
          if (img_rdy) overrun_q <= 1'b1;
          if (abort_act || (win_ready && last_c)) begin
            state_q <= StDone;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          if (img_rdy) overrun_q <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign win_valid = valid_q;
  assign win_last  = valid_q & last_c;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pyramid_scan_ctrl.sv
// Directed bench for pyramid_scan_ctrl over four small geometries.
module tb_pyramid_scan_ctrl;

  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        img_rdy   [ND];
  logic        win_ready [ND];
  logic        win_valid [ND];
  logic        win_last  [ND];
  logic        busy      [ND];
  logic        done      [ND];
  logic        overrun   [ND];
  logic [3:0]  win_level [ND];
  logic [15:0] win_row   [ND];
  logic [15:0] win_col   [ND];
`ifdef SCAN_ABORT_EN
  logic        abort     [ND];
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  lvl;
    logic [15:0] row;
    logic [15:0] col;
    logic        last;
    logic        acc;
    logic        busy;
    int          cyc;
  } win_rec_t;

  win_rec_t win_q[$];
  int       done_cyc;
  int       first_cyc;
  bit       timed_out;

  always #5 clk = ~clk;

  // A: 26x25 single level, stride 1, wait 4
  pyramid_scan_ctrl #(
    .LEVELS(1), .WINDOW(24), .STEP(1), .WAIT_CYCLES(4),
    .LVL_W(16'd26), .LVL_H(16'd25)
  ) u_a (
    .clock(clk), .reset(rst), .img_rdy(img_rdy[0]), .win_ready(win_ready[0]),
`ifdef SCAN_ABORT_EN
    .abort(abort[0]),
`endif
    .win_valid(win_valid[0]), .win_level(win_level[0]), .win_row(win_row[0]),
    .win_col(win_col[0]), .win_last(win_last[0]), .busy(busy[0]), .done(done[0]),
    .overrun(overrun[0])
  );

  // B: three levels, level 1 too small
  pyramid_scan_ctrl #(
    .LEVELS(3), .WINDOW(24), .STEP(1), .WAIT_CYCLES(2),
    .LVL_W({16'd24, 16'd20, 16'd26}), .LVL_H({16'd25, 16'd20, 16'd24})
  ) u_b (
    .clock(clk), .reset(rst), .img_rdy(img_rdy[1]), .win_ready(win_ready[1]),
`ifdef SCAN_ABORT_EN
    .abort(abort[1]),
`endif
    .win_valid(win_valid[1]), .win_level(win_level[1]), .win_row(win_row[1]),
    .win_col(win_col[1]), .win_last(win_last[1]), .busy(busy[1]), .done(done[1]),
    .overrun(overrun[1])
  );

  // C: 33x24, stride 4
  pyramid_scan_ctrl #(
    .LEVELS(1), .WINDOW(24), .STEP(4), .WAIT_CYCLES(1),
    .LVL_W(16'd33), .LVL_H(16'd24)
  ) u_c (
    .clock(clk), .reset(rst), .img_rdy(img_rdy[2]), .win_ready(win_ready[2]),
`ifdef SCAN_ABORT_EN
    .abort(abort[2]),
`endif
    .win_valid(win_valid[2]), .win_level(win_level[2]), .win_row(win_row[2]),
    .win_col(win_col[2]), .win_last(win_last[2]), .busy(busy[2]), .done(done[2]),
    .overrun(overrun[2])
  );

  // D: no eligible level
  pyramid_scan_ctrl #(
    .LEVELS(1), .WINDOW(24), .STEP(1), .WAIT_CYCLES(2),
    .LVL_W(16'd20), .LVL_H(16'd30)
  ) u_d (
    .clock(clk), .reset(rst), .img_rdy(img_rdy[3]), .win_ready(win_ready[3]),
`ifdef SCAN_ABORT_EN
    .abort(abort[3]),
`endif
    .win_valid(win_valid[3]), .win_level(win_level[3]), .win_row(win_row[3]),
    .win_col(win_col[3]), .win_last(win_last[3]), .busy(busy[3]), .done(done[3]),
    .overrun(overrun[3])
  );

  // Runs one frame on DUT d; pat gives win_ready per valid cycle, ovr_at re-pulses img_rdy.
  task automatic capture(input int d, input bit [3:0] pat, input int plen, input int ovr_at,
                         input int bound);
    int       idx = 0;
    win_rec_t r;
    repeat (2) @(negedge clk);
    win_q.delete();
    done_cyc  = -1;
    first_cyc = -1;
    timed_out = 1'b1;
    img_rdy[d] = 1'b1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      img_rdy[d] = (i == ovr_at);
      if (done[d]) begin
        done_cyc  = i;
        timed_out = 1'b0;
        break;
      end
      if (win_valid[d]) begin
        if (first_cyc < 0) first_cyc = i;
        r.lvl  = win_level[d];
        r.row  = win_row[d];
        r.col  = win_col[d];
        r.last = win_last[d];
        r.busy = busy[d];
        r.acc  = pat[idx % plen];
        r.cyc  = i;
        idx++;
        win_ready[d] = r.acc;
        win_q.push_back(r);
      end
    end
    img_rdy[d]   = 1'b0;
    win_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if ({win_valid[d], win_last[d], busy[d], done[d], overrun[d]} !== 5'b0) begin
        failures++;
        $display("FAIL reset_flags dut%0d: got %b want 00000", d,
                 {win_valid[d], win_last[d], busy[d], done[d], overrun[d]});
      end
      checks++;
      if (win_level[d] !== 4'd0) begin
        failures++;
        $display("FAIL reset_level dut%0d: got %0d want 0", d, win_level[d]);
      end
      checks++;
      if ({win_row[d], win_col[d]} !== 32'd0) begin
        failures++;
        $display("FAIL reset_coord dut%0d: got (%0d,%0d) want (0,0)", d, win_row[d], win_col[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int er[6] = '{0, 0, 0, 1, 1, 1};
    int ec[6] = '{0, 1, 2, 0, 1, 2};
    int k = 0;
    int last_acc = -1;
    capture(0, 4'b0001, 1, -1, 100);
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL basic_done: got no done want done pulse");
    end
    checks++;
    if (first_cyc != 5) begin
      failures++;
      $display("FAIL basic_latency: got %0d want 5", first_cyc);
    end
    foreach (win_q[j]) begin
      if (win_q[j].acc) begin
        if (k < 6) begin
          checks++;
          if (win_q[j].lvl !== 4'd0 || win_q[j].row !== 16'(er[k]) ||
              win_q[j].col !== 16'(ec[k]) || win_q[j].last !== (k == 5) ||
              win_q[j].busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_win%0d: got (%0d,%0d,%0d,last=%0b) want (0,%0d,%0d,last=%0b)",
                     k, win_q[j].lvl, win_q[j].row, win_q[j].col, win_q[j].last,
                     er[k], ec[k], k == 5);
          end
        end
        last_acc = win_q[j].cyc;
        k++;
      end
    end
    checks++;
    if (k != 6) begin
      failures++;
      $display("FAIL basic_count: got %0d want 6", k);
    end
    checks++;
    if (done_cyc != last_acc + 1) begin
      failures++;
      $display("FAIL basic_done_time: got %0d want %0d", done_cyc, last_acc + 1);
    end
    @(negedge clk);
    checks++;
    if ({done[0], busy[0], win_valid[0]} !== 3'b000) begin
      failures++;
      $display("FAIL basic_after_done: got %b want 000", {done[0], busy[0], win_valid[0]});
    end
  endtask

  task automatic test_stall();
    int er[6] = '{0, 0, 0, 1, 1, 1};
    int ec[6] = '{0, 1, 2, 0, 1, 2};
    int k = 0;
    capture(0, 4'b1001, 4, -1, 100);
    checks++;
    if (timed_out || win_q.size() != 12) begin
      failures++;
      $display("FAIL stall_entries: got %0d (timeout=%0b) want 12", win_q.size(), timed_out);
    end
    foreach (win_q[j]) begin
      if (win_q[j].acc) begin
        if (k < 6) begin
          checks++;
          if (win_q[j].row !== 16'(er[k]) || win_q[j].col !== 16'(ec[k])) begin
            failures++;
            $display("FAIL stall_win%0d: got (%0d,%0d) want (%0d,%0d)", k,
                     win_q[j].row, win_q[j].col, er[k], ec[k]);
          end
        end
        k++;
      end else if (j + 1 < win_q.size()) begin
        checks++;
        if (win_q[j].row !== win_q[j+1].row || win_q[j].col !== win_q[j+1].col ||
            win_q[j].lvl !== win_q[j+1].lvl) begin
          failures++;
          $display("FAIL stall_hold%0d: got (%0d,%0d) then (%0d,%0d) want equal", j,
                   win_q[j].row, win_q[j].col, win_q[j+1].row, win_q[j+1].col);
        end
      end
    end
    checks++;
    if (k != 6) begin
      failures++;
      $display("FAIL stall_count: got %0d want 6", k);
    end
  endtask

  task automatic test_skip();
    int el[5] = '{0, 0, 0, 2, 2};
    int er[5] = '{0, 0, 0, 0, 1};
    int ec[5] = '{0, 1, 2, 0, 0};
    int ac[5];
    int k = 0;
    capture(1, 4'b0001, 1, -1, 100);
    foreach (win_q[j]) begin
      if (k < 5) begin
        checks++;
        if (win_q[j].lvl !== 4'(el[k]) || win_q[j].row !== 16'(er[k]) ||
            win_q[j].col !== 16'(ec[k]) || win_q[j].last !== (k == 4)) begin
          failures++;
          $display("FAIL skip_win%0d: got (%0d,%0d,%0d,last=%0b) want (%0d,%0d,%0d,last=%0b)",
                   k, win_q[j].lvl, win_q[j].row, win_q[j].col, win_q[j].last,
                   el[k], er[k], ec[k], k == 4);
        end
        ac[k] = win_q[j].cyc;
      end
      k++;
    end
    checks++;
    if (timed_out || k != 5) begin
      failures++;
      $display("FAIL skip_count: got %0d (timeout=%0b) want 5", k, timed_out);
    end else begin
      checks++;
      if (ac[3] != ac[2] + 1) begin
        failures++;
        $display("FAIL skip_gap: got level2 at %0d want %0d", ac[3], ac[2] + 1);
      end
    end
  endtask

  task automatic test_step();
    int k = 0;
    capture(2, 4'b0001, 1, -1, 100);
    foreach (win_q[j]) begin
      if (k < 3) begin
        checks++;
        if (win_q[j].row !== 16'd0 || win_q[j].col !== 16'(4 * k) ||
            win_q[j].last !== (k == 2)) begin
          failures++;
          $display("FAIL step_win%0d: got (%0d,%0d,last=%0b) want (0,%0d,last=%0b)", k,
                   win_q[j].row, win_q[j].col, win_q[j].last, 4 * k, k == 2);
        end
      end
      k++;
    end
    checks++;
    if (timed_out || k != 3) begin
      failures++;
      $display("FAIL step_count: got %0d (timeout=%0b) want 3", k, timed_out);
    end
  endtask

  task automatic test_no_elig();
    capture(3, 4'b0001, 1, -1, 50);
    checks++;
    if (first_cyc != -1 || done_cyc != 3) begin
      failures++;
      $display("FAIL noelig: got first_valid=%0d done_at=%0d want -1 and 3", first_cyc, done_cyc);
    end
  endtask

  task automatic test_overrun();
    capture(0, 4'b0001, 1, 7, 100);
    checks++;
    if (overrun[0] !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set: got %b want 1", overrun[0]);
    end
    checks++;
    if (timed_out || win_q.size() != 6 || win_q[win_q.size()-1].row !== 16'd1 ||
        win_q[win_q.size()-1].col !== 16'd2) begin
      failures++;
      $display("FAIL ovr_scan: got %0d windows (timeout=%0b) want 6 ending (1,2)",
               win_q.size(), timed_out);
    end
    capture(0, 4'b0001, 1, -1, 100);
    checks++;
    if (overrun[0] !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear: got %b want 0", overrun[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit bad = 1'b0;
    repeat (2) @(negedge clk);
    win_ready[0] = 1'b1;
    img_rdy[0]   = 1'b1;
    @(negedge clk);
    img_rdy[0] = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (win_valid[0] !== 1'b1 || win_col[0] === 16'd0) begin
      failures++;
      $display("FAIL rstmid_pre: got valid=%b col=%0d want valid=1 col>0", win_valid[0],
               win_col[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({win_valid[0], win_last[0], busy[0], done[0], overrun[0]} !== 5'b0 ||
        {win_level[0], win_row[0], win_col[0]} !== 36'd0) begin
      failures++;
      $display("FAIL rstmid_outputs: got flags=%b lvl=%0d row=%0d col=%0d want all 0",
               {win_valid[0], win_last[0], busy[0], done[0], overrun[0]},
               win_level[0], win_row[0], win_col[0]);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done[0] || win_valid[0]) bad = 1'b1;
    end
    win_ready[0] = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL rstmid_nodone: got done/valid after reset want none");
    end
  endtask

`ifdef SCAN_ABORT_EN
  task automatic test_abort();
    int n = 0;
    repeat (2) @(negedge clk);
    img_rdy[0] = 1'b1;
    @(negedge clk);
    img_rdy[0] = 1'b0;
    while (!win_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    checks++;
    if ({done[0], win_valid[0], busy[0]} !== 3'b100) begin
      failures++;
      $display("FAIL abort_done: got done,valid,busy=%b want 100", {done[0], win_valid[0], busy[0]});
    end
    @(negedge clk);
    checks++;
    if (done[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_pulse: got %b want 0", done[0]);
    end
  endtask
`endif

  initial begin
    for (int d = 0; d < ND; d++) begin
      img_rdy[d]   = 1'b0;
      win_ready[d] = 1'b0;
`ifdef SCAN_ABORT_EN
      abort[d]     = 1'b0;
`endif
    end
    test_reset();
    test_basic();
    test_stall();
    test_skip();
    test_step();
    test_no_elig();
    test_overrun();
    test_reset_mid();
`ifdef SCAN_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pyramid_scan_ctrl.md
PYRAMID_SCAN_CTRL -- requirements
Module: pyramid_scan_ctrl

Interface
REQ-001 Parameter LEVELS, default 10: number of pyramid levels scanned, 1..16.
REQ-002 Parameter WINDOW, default 24: square scan-window edge, in pixels.
REQ-003 Parameter STEP, default 1: row and column stride, 1..8.
REQ-004 Parameter WAIT_CYCLES, default 76800: cycles from frame accept to first window (integral-image settle time), at least 1.
REQ-005 Parameters LVL_W and LVL_H, each LEVELS x 16 bits: per-level image width and height, level 0 largest.
REQ-006 clock  input  1  sole clock, rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 img_rdy  input  1  new frame available, single-cycle pulse.
REQ-009 win_ready  input  1  downstream vj pipeline accepts the window.
REQ-010 win_valid  output  1  win_level, win_row, win_col and win_last are valid.
REQ-011 win_level  output  4  pyramid level of the current window.
REQ-012 win_row, win_col  output  16 each  top-left coordinate of the window in level pixels.
REQ-013 win_last  output  1  window is the final one of the frame.
REQ-014 busy  output  1  high in WAIT and SCAN.
REQ-015 done  output  1  one-cycle pulse at frame completion.
REQ-016 overrun  output  1  sticky flag: img_rdy was dropped while busy.

Function
REQ-017 States SHALL be IDLE, WAIT, SCAN and DONE, encoded in a package enum.
REQ-018 IDLE + img_rdy -> WAIT: clear the wait counter, clear overrun.
REQ-019 WAIT SHALL count to WAIT_CYCLES, then -> SCAN with level = first eligible level, row = 0, col = 0, win_valid = 1 on the first SCAN cycle.
REQ-020 A level is eligible iff LVL_W >= WINDOW and LVL_H >= WINDOW; ineligible levels SHALL be skipped with no cycle penalty.
REQ-021 If no level is eligible, WAIT SHALL go directly to DONE.
REQ-022 In SCAN, win_valid SHALL be held high, and the coordinates SHALL be held stable until win_valid and win_ready are both high.
REQ-023 Advance on handshake:
- if col + STEP <= LVL_W - WINDOW: col += STEP;
- else if row + STEP <= LVL_H - WINDOW: col = 0, row += STEP;
- else: level = next eligible level, row = 0, col = 0.
REQ-024 win_last SHALL be high exactly when the current window has no successor under REQ-023.
REQ-025 A handshake with win_last SHALL go to DONE; DONE asserts done for one cycle, then -> IDLE.
REQ-026 img_rdy in WAIT, SCAN or DONE SHALL be ignored and SHALL set overrun; img_rdy in IDLE is accepted.
REQ-027 Throughput SHALL be one window per cycle while win_ready is held high.
REQ-028 Coordinate comparisons SHALL be computed in 17 bits so they never wrap.

Reset
REQ-029 When reset is high, on the next clock edge: state = IDLE, and win_valid, win_last, busy, done and overrun = 0.
REQ-030 On the same edge, win_level, win_row, win_col and the wait counter = 0.
REQ-031 Reset asserted in any state SHALL abort the frame, with no done pulse.

Configuration
REQ-032 With SCAN_ABORT_EN defined, the module SHALL have an extra input abort, 1 bit.
REQ-033 abort high in WAIT or SCAN SHALL drop the window without a handshake, go to DONE and pulse done.
REQ-034 Without SCAN_ABORT_EN, the abort port and its logic SHALL be absent.

Structure
REQ-035 Package vj_scan_pkg SHALL hold the state enum, the 16-bit coordinate typedef and the default LVL_W/LVL_H constants (320x240 downscaled by 1.25 per level).
REQ-036 Sub-module scan_coord_gen SHALL hold the level/row/col counters and the last-window logic; the FSM stays in the top module.

Verification
REQ-037 LEVELS=1, 26x25 image, WINDOW=24, STEP=1, WAIT_CYCLES=4, win_ready held high -> first win_valid 5 cycles after img_rdy; then (0,0,0), (0,0,1), (0,0,2), (0,1,0), (0,1,1), (0,1,2) as (level,row,col), with win_last on the sixth window; done 1 cycle later.
REQ-038 Same setup with win_ready toggled 1,0,0,1 -> coordinates held during the stalls; no window skipped or repeated.
REQ-039 LEVELS=3 with level 1 at 20x20 -> no window emitted for level 1; level 2 starts immediately after level 0's last window.
REQ-040 img_rdy pulsed in SCAN -> overrun=1 and the scan is unaffected; the next accepted img_rdy clears overrun.
REQ-041 STEP=4 on 33x24 -> columns 0, 4, 8 then win_last; column 9 is never emitted.
REQ-042 Reset mid-SCAN -> next cycle all outputs 0, state IDLE, no done pulse; with SCAN_ABORT_EN, abort in SCAN -> done pulse on the next cycle.
